pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset and lock sequencer for the system PLL. Runs on the free-running 50 MHz board reference clock and drives the PLL's active-high reset input. Watches the PLL `locked` output and releases the design-wide reset only after lock has stayed stable for a programmable interval. Re-arms automatically on lock timeout or loss of lock; downstream blocks resynchronise `sys_rst_n` into the `outclk_0` and `outclk_1` domains.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: refclk edges `pll_rst` is held high per attempt; must be ≥2.
- `LOCK_STABLE_CYCLES`, default 1024: edges `locked` must stay continuously high before the system reset is released; must be ≥2.
- `LOCK_TIMEOUT_CYCLES`, default 65536: edges allowed in WAIT_LOCK before the PLL is reset again; must be ≥2.

Ports:
- `refclk`  in  1  board reference clock, 50 MHz, free-running; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock indicator; asynchronous to `refclk`.
- `pll_rst`  out  1  active-high reset to the PLL.
- `sys_rst_n`  out  1  active-low system reset, `refclk` domain.
- `ready`  out  1  high only in RUN.
- `retry_count`  out  4  count of lock timeouts; saturates at 15.
- `lost_lock`  out  1  sticky; set on loss of lock in RUN.

## Operation
- `locked` passes through a 2-flop synchroniser. The result is `locked_s`, and the FSM uses only `locked_s`.
- A single shared counter `cnt` is used. Its width is `$clog2` of the largest parameter. It clears on every state change.
- All outputs are registered and update on the same edge as the state change, so they reflect the state just entered.
- FSM states and transitions:
  - PLL_RESET: `pll_rst`=1, `sys_rst_n`=0. When `cnt`==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0, `sys_rst_n`=0. If `locked_s`=1, go to STABLE. Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET and increment `retry_count` (saturating at 15).
  - STABLE: `pll_rst`=0, `sys_rst_n`=0. If `locked_s`=0, go to WAIT_LOCK; the timeout restarts and `retry_count` is unchanged. When `cnt`==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
  - RUN: `pll_rst`=0, `sys_rst_n`=1, `ready`=1. If `locked_s`=0, go to PLL_RESET and set `lost_lock`=1.
- Simultaneous events in STABLE: if `locked_s`=0 on the same edge that `cnt` reaches terminal, the lock drop wins and the FSM goes to WAIT_LOCK.
- Simultaneous events in WAIT_LOCK: if `locked_s`=1 on the same edge that the timeout expires, lock wins and the FSM goes to STABLE with no retry increment.
- `retry_count` and `lost_lock` clear only on `rst_n`.

## Timing
- Reset values while `rst_n`=0 (asynchronous): state PLL_RESET, `cnt`=0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `retry_count`=0, `lost_lock`=0, synchroniser flops 0.
- After `rst_n` rises, `pll_rst` stays high for exactly PLL_RST_CYCLES rising edges, then falls.
- Lock-to-release latency: `sys_rst_n` and `ready` rise after the (LOCK_STABLE_CYCLES+2)-th edge, counting from and including the edge that first samples `locked`=1 (2 synchroniser edges plus LOCK_STABLE_CYCLES).
- Loss-of-lock latency: `sys_rst_n` falls after the 3rd edge, counting the edge that first samples `locked`=0. `pll_rst`, `ready`=0 and `lost_lock`=1 change on that same edge.
- Timeout retry period with `locked` stuck low: PLL_RST_CYCLES + LOCK_TIMEOUT_CYCLES edges per attempt.
- Reset mid-operation: asserting `rst_n` in any state forces the reset values immediately, without waiting for a clock edge.
- Deassertion of `sys_rst_n` is glitch-free: it comes straight from a flop.

## Test plan
Parameters for the bench: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
- Nominal bring-up: release `rst_n`, raise `locked` 10 edges later. Expect `pll_rst` high for exactly 4 edges, and `sys_rst_n`=`ready`=1 after the 10th edge counting the first `locked`-sampling edge. `retry_count`=0, `lost_lock`=0.
- Glitch during STABLE: drop `locked` for 1 cycle when `cnt`=5. Expect the FSM to return to WAIT_LOCK with `sys_rst_n` still 0. Release then occurs 10 edges after the first sample of `locked`=1 following the glitch. `retry_count`=0.
- Timeout and saturation: hold `locked`=0. Expect a 4-edge `pll_rst` pulse every 36 edges, and `retry_count` stepping 1,2,…,15 and holding at 15 after 16+ timeouts.
- Loss of lock in RUN: drop `locked` once in RUN. Expect `sys_rst_n`, `ready`=0, `pll_rst`=1 and `lost_lock`=1 after the 3rd edge, followed by a 4-edge `pll_rst` pulse. On relock, `sys_rst_n` returns to 1 and `lost_lock` stays 1.
- Asynchronous reset mid-STABLE: assert `rst_n` between clock edges. Expect all outputs at their reset values before the next edge: `pll_rst`=1, `sys_rst_n`=0, `retry_count`=0, `lost_lock`=0.
- Coincident events: force `locked_s` low on the STABLE terminal edge, and `locked_s` high on the WAIT_LOCK timeout edge. Expect WAIT_LOCK in the first case, and STABLE with no retry increment in the second.

Source files
------------

// File: rtl/pll_reset_seq.sv
// PLL reset and lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the refclk-domain system reset. Re-arms on timeout or loss of lock.
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic       lost_lock
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK->STABLE edge already saw locked_s high, so it counts as the
  // first stable edge; the dwell in STABLE itself is one edge shorter.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 2);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic [3:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             locked_s;

  assign sync_d   = {sync_q[0], locked};
  assign locked_s = sync_q[1];

  // Next state, shared counter, sticky status and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lost_d      = lost_q;
    pll_rst_d   = 1'b0;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;

    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = PLL_RESET;
          if (retry_q != 4'd15) retry_d = retry_q + 4'd1;
        end
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = PLL_RESET;
          lost_d  = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    if (state_d != state_q) cnt_d = '0;

    pll_rst_d   = (state_d == PLL_RESET);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;
  assign lost_lock   = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with PLL_RST=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
// Outputs are sampled 1 time unit after each rising refclk edge.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [3:0] retry_count;
  logic       lost_lock;

  int n_cmp;
  int n_bad;

  pll_reset_seq #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .retry_count(retry_count),
    .lost_lock  (lost_lock)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic       lk;
    int         n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  // Expected output vector: {pll_rst, sys_rst_n, ready, retry_count, lost_lock}
  function automatic logic [7:0] pk(input logic p, input logic s, input logic r,
                                    input logic [3:0] rc, input logic l);
    return {p, s, r, rc, l};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {pll_rst, sys_rst_n, ready, retry_count, lost_lock};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: pll_rst/sys_rst_n/ready/retry/lost got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
               nm, act[7], act[6], act[5], act[4:1], act[0],
               exp[7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Pulse rst_n across one edge, leaving the bench 1 unit after that edge
  task automatic do_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    tick(1);
    rst_n  = 1'b1;
  endtask

  vec_t tbl[6];

  initial begin
    logic [3:0] rc;

    n_cmp = 0;
    n_bad = 0;

    // Nominal bring-up: locked rises after E10, first sampled on E11 (L1)
    tbl[0] = '{1'b0, 3, pk(1, 0, 0, 4'd0, 0), "nom_pll_rst_e3"};
    tbl[1] = '{1'b0, 1, pk(0, 0, 0, 4'd0, 0), "nom_pll_rst_fall_e4"};
    tbl[2] = '{1'b0, 6, pk(0, 0, 0, 4'd0, 0), "nom_wait_e10"};
    tbl[3] = '{1'b1, 9, pk(0, 0, 0, 4'd0, 0), "nom_held_l9"};
    tbl[4] = '{1'b1, 1, pk(0, 1, 1, 4'd0, 0), "nom_release_l10"};
    tbl[5] = '{1'b1, 5, pk(0, 1, 1, 4'd0, 0), "nom_run_hold"};

    rst_n  = 1'b1;
    locked = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("reset_async_vals", pk(1, 0, 0, 4'd0, 0));
    tick(2);
    chk("reset_held_vals", pk(1, 0, 0, 4'd0, 0));

    // Timeout and retry saturation with locked stuck low
    rst_n = 1'b1;
    tick(3);
    chk("tmo_pll_rst_e3", pk(1, 0, 0, 4'd0, 0));
    tick(1);
    chk("tmo_pll_rst_fall_e4", pk(0, 0, 0, 4'd0, 0));
    for (int n = 1; n <= 17; n++) begin
      rc = 4'((n - 1) > 15 ? 15 : (n - 1));
      tick(31);
      chk($sformatf("tmo_before_%0d", n), pk(0, 0, 0, rc, 0));
      rc = 4'(n > 15 ? 15 : n);
      tick(1);
      chk($sformatf("tmo_pulse_start_%0d", n), pk(1, 0, 0, rc, 0));
      tick(3);
      chk($sformatf("tmo_pulse_hold_%0d", n), pk(1, 0, 0, rc, 0));
      tick(1);
      chk($sformatf("tmo_pulse_end_%0d", n), pk(0, 0, 0, rc, 0));
    end

    // Asynchronous reset while in STABLE
    locked = 1'b1;
    tick(6);
    chk("stable_pre_async", pk(0, 0, 0, 4'd15, 0));
    #3 rst_n = 1'b0;
    #1 chk("async_rst_stable", pk(1, 0, 0, 4'd0, 0));
    locked = 1'b0;
    tick(1);
    chk("async_rst_held", pk(1, 0, 0, 4'd0, 0));

    // Table-driven nominal bring-up
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      locked = tbl[i].lk;
      tick(tbl[i].n);
      chk(tbl[i].name, tbl[i].exp);
    end

    // Loss of lock in RUN, then relock
    locked = 1'b0;
    tick(2);
    chk("lol_still_run_m2", pk(0, 1, 1, 4'd0, 0));
    tick(1);
    chk("lol_drop_m3", pk(1, 0, 0, 4'd0, 1));
    tick(3);
    chk("lol_pulse_m6", pk(1, 0, 0, 4'd0, 1));
    tick(1);
    chk("lol_pulse_end_m7", pk(0, 0, 0, 4'd0, 1));
    locked = 1'b1;
    tick(9);
    chk("lol_relock_held", pk(0, 0, 0, 4'd0, 1));
    tick(1);
    chk("lol_relock_release", pk(0, 1, 1, 4'd0, 1));

    // Asynchronous reset from RUN clears the sticky flag
    #3 rst_n = 1'b0;
    #1 chk("async_rst_run", pk(1, 0, 0, 4'd0, 0));
    locked = 1'b0;
    tick(1);

    // One-cycle glitch on locked while STABLE
    rst_n = 1'b1;
    tick(4);
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("glitch_back_to_wait", pk(0, 0, 0, 4'd0, 0));
    tick(1);
    chk("glitch_no_early_rel", pk(0, 0, 0, 4'd0, 0));
    tick(6);
    chk("glitch_held_g9", pk(0, 0, 0, 4'd0, 0));
    tick(1);
    chk("glitch_release_g10", pk(0, 1, 1, 4'd0, 0));

    // locked_s low exactly on the STABLE terminal edge
    do_reset();
    tick(4);
    locked = 1'b1;
    tick(7);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("tie_stable_drop_wins", pk(0, 0, 0, 4'd0, 0));
    tick(7);
    chk("tie_stable_held", pk(0, 0, 0, 4'd0, 0));
    tick(1);
    chk("tie_stable_release", pk(0, 1, 1, 4'd0, 0));

    // locked_s high exactly on the WAIT_LOCK timeout edge
    do_reset();
    tick(33);
    locked = 1'b1;
    tick(3);
    chk("tie_wait_lock_wins", pk(0, 0, 0, 4'd0, 0));
    tick(6);
    chk("tie_wait_held", pk(0, 0, 0, 4'd0, 0));
    tick(1);
    chk("tie_wait_release", pk(0, 1, 1, 4'd0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
